// File: rtl/usb_kbd_pkg.sv
// Shared constants, event-FSM state encoding and sizing helper for the keyboard byte path.
package usb_kbd_pkg;

  localparam logic [7:0] NO_KEY         = 8'h00;
  localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OLD  = 2'd1,
    NEW  = 2'd2
  } ev_state_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/key_byte_fifo.sv
// Byte FIFO with first-word fall-through head; a push into a full FIFO is accepted only alongside a pop.
module key_byte_fifo
  import usb_kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  // Empty FIFO presents 00 so the head is defined straight out of reset.
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/usb_key_event_queue.sv
// Debounces the USB HID keycode and turns accepted code changes into queued make/break bytes.
module usb_key_event_queue
  import usb_kbd_pkg::*;
#(
  parameter int         STABLE_CYCLES = 4,
  parameter int         DEPTH         = 8,
  parameter logic [7:0] BREAK_CODE    = BREAK_CODE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 usb_data,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic [7:0]    usb_q;
  logic [7:0]    cand;
  logic [7:0]    accepted;
  logic [7:0]    prev;
  logic [SW-1:0] cnt;
  ev_state_t     state;
  logic          accept;
  logic          push;
  logic [7:0]    din;
  logic          pop;
  logic          full;
  logic          empty;
  logic          drop;

  assign accept   = (cnt == SW'(STABLE_CYCLES)) && (cand != accepted) && (state == IDLE);
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;
  assign drop     = push && full && !pop;

  // accepted already holds the new code once the FSM leaves IDLE.
  always_comb begin
    push = 1'b0;
    din  = 8'h00;
    case (state)
      IDLE: begin
        push = accept;
        din  = (accepted == NO_KEY) ? cand : BREAK_CODE;
      end
      OLD: begin
        push = 1'b1;
        din  = prev;
      end
      NEW: begin
        push = 1'b1;
        din  = accepted;
      end
      default: begin
        push = 1'b0;
        din  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      usb_q    <= NO_KEY;
      cand     <= NO_KEY;
      accepted <= NO_KEY;
      prev     <= NO_KEY;
      cnt      <= '0;
      state    <= IDLE;
      overflow <= 1'b0;
    end else begin
      usb_q <= usb_data;
      if (usb_q != cand) begin
        cand <= usb_q;
        cnt  <= SW'(1);
      end else if (cnt != SW'(STABLE_CYCLES)) begin
        cnt <= cnt + SW'(1);
      end

      case (state)
        IDLE: begin
          if (accept) begin
            accepted <= cand;
            prev     <= accepted;
            if (accepted != NO_KEY) state <= OLD;
          end
        end
        OLD:     state <= (accepted == NO_KEY) ? IDLE : NEW;
        NEW:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  key_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (tx_data),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_usb_key_event_queue.sv
// Directed and randomized checks of the key event queue against a byte-stream reference model.
module tb_usb_key_event_queue;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic [7:0] usb_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clr_overflow;

  int         errors;
  int         checks;
  bit         sb_on;
  logic [7:0] exp_q[$];

  usb_key_event_queue #(.STABLE_CYCLES(4), .DEPTH(DEPTH), .BREAK_CODE(8'hF0)) dut (
    .clk          (clk),
    .rst          (rst),
    .usb_data     (usb_data),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; while the scoreboard is on, every handshake is checked against the model queue.
  task automatic cyc(input logic [7:0] d, input logic rdy);
    usb_data = d;
    tx_ready = rdy;
    if (sb_on && fifo_count >= 4'd6) tx_ready = 1'b1;
    #1;
    if (sb_on && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else                   chk("sb_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [7:0] key);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      usb_data = key;
      tx_ready = 1'b1;
      #1;
      chk("drain_valid", {31'h0, tx_valid}, 32'h1);
      chk("drain_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      @(posedge clk);
      #1;
    end
    chk("drain_empty", {31'h0, tx_valid}, 32'h0);
  endtask

  // Reference: byte stream caused by a change of the held key from old to nw.
  task automatic model_event(input logic [7:0] old, input logic [7:0] nw);
    if (old != nw) begin
      if (old == 8'h00) exp_q.push_back(nw);
      else begin
        exp_q.push_back(8'hF0);
        exp_q.push_back(old);
        if (nw != 8'h00) exp_q.push_back(nw);
      end
    end
  endtask

  initial begin
    logic [7:0] keys [5];
    logic [7:0] model_key;
    logic [7:0] prev_val;
    logic [7:0] val;
    bit         glitch;
    bit         seen;
    int         dur;
    int         idx;

    keys[0] = 8'h00; keys[1] = 8'h1C; keys[2] = 8'h1D; keys[3] = 8'h23; keys[4] = 8'h2B;
    errors = 0; checks = 0; sb_on = 1'b0;
    rst = 1'b1; usb_data = 8'h00; tx_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_count", {28'h0, fifo_count}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    rst = 1'b0;

    // Single make with first-valid timing.
    for (int e = 1; e <= 8; e++) begin
      cyc(8'h1C, 1'b1);
      if (e == 5) chk("make_lat_e5", {31'h0, tx_valid}, 32'h0);
      if (e == 6) begin
        chk("make_lat_e6", {31'h0, tx_valid}, 32'h1);
        chk("make_byte", {24'h0, tx_data}, 32'h1C);
      end
      if (e == 7) chk("make_popped", {31'h0, tx_valid}, 32'h0);
    end
    seen = 1'b0;
    repeat (20) begin cyc(8'h1C, 1'b1); if (tx_valid) seen = 1'b1; end
    chk("make_idle", {31'h0, seen}, 32'h0);

    // Key change 1C -> 1D: three bytes on successive cycles.
    for (int e = 1; e <= 8; e++) begin
      cyc(8'h1D, 1'b0);
      if (e == 5) chk("chg_cnt_e5", {28'h0, fifo_count}, 32'd0);
      if (e == 6) chk("chg_cnt_e6", {28'h0, fifo_count}, 32'd1);
      if (e == 7) chk("chg_cnt_e7", {28'h0, fifo_count}, 32'd2);
      if (e == 8) chk("chg_cnt_e8", {28'h0, fifo_count}, 32'd3);
    end
    repeat (5) cyc(8'h1D, 1'b0);
    chk("chg_cnt_hold", {28'h0, fifo_count}, 32'd3);
    exp_q = '{8'hF0, 8'h1C, 8'h1D};
    drain(8'h1D);

    // Release: break then old code, nothing more while 00 held.
    repeat (20) cyc(8'h00, 1'b0);
    chk("rel_cnt", {28'h0, fifo_count}, 32'd2);
    exp_q = '{8'hF0, 8'h1D};
    drain(8'h00);
    repeat (20) cyc(8'h00, 1'b0);
    chk("rel_quiet", {28'h0, fifo_count}, 32'd0);

    // Short glitch is ignored.
    seen = 1'b0;
    repeat (2) begin cyc(8'h1C, 1'b1); if (tx_valid) seen = 1'b1; end
    repeat (20) begin cyc(8'h00, 1'b1); if (tx_valid) seen = 1'b1; end
    chk("glitch_no_byte", {31'h0, seen}, 32'h0);

    // Overflow: nine bytes generated with consumer stalled.
    for (int s = 0; s < 6; s++) repeat (10) cyc((s % 2 == 0) ? 8'h1C : 8'h00, 1'b0);
    chk("ovf_cnt", {28'h0, fifo_count}, 32'd8);
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    chk("ovf_head_stable", {24'h0, tx_data}, 32'h1C);
    exp_q = '{8'h1C, 8'hF0, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C, 8'hF0};
    drain(8'h00);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
    clr_overflow = 1'b1;
    cyc(8'h00, 1'b0);
    clr_overflow = 1'b0;
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);

    // Asynchronous reset while the FSM is in OLD with two bytes queued.
    repeat (10) cyc(8'h1C, 1'b0);
    chk("mid_cnt1", {28'h0, fifo_count}, 32'd1);
    repeat (6) cyc(8'h00, 1'b0);
    chk("mid_cnt2", {28'h0, fifo_count}, 32'd2);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, tx_valid}, 32'h0);
    chk("arst_cnt", {28'h0, fifo_count}, 32'd0);
    repeat (2) cyc(8'h1D, 1'b0);
    rst = 1'b0;
    repeat (15) cyc(8'h1D, 1'b0);
    chk("post_rst_cnt", {28'h0, fifo_count}, 32'd1);
    exp_q = '{8'h1D};
    drain(8'h1D);

    // Randomized key holds and glitches against the byte-stream model.
    model_key = 8'h1D;
    prev_val  = 8'h1D;
    sb_on     = 1'b1;
    for (int seg = 0; seg < 40; seg++) begin
      glitch = ($urandom_range(0, 3) == 0);
      idx    = $urandom_range(0, 4);
      val    = keys[idx];
      if (glitch && val == prev_val) val = keys[(idx + 1) % 5];
      dur = glitch ? $urandom_range(1, 3) : $urandom_range(10, 18);
      if (!glitch) begin
        model_event(model_key, val);
        model_key = val;
      end
      repeat (dur) cyc(val, ($urandom_range(0, 3) != 0));
      prev_val = val;
    end
    repeat (40) cyc(model_key, 1'b1);
    chk("rand_all_seen", exp_q.size(), 32'd0);
    chk("rand_cnt", {28'h0, fifo_count}, 32'd0);
    chk("rand_no_ovf", {31'h0, overflow}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
